// File: rtl/pipelined_barrel_shifter.sv
// Pipelined shift/rotate unit. There is one registered mux stage per shift-amount bit,
// and the stages advance together under a valid/ready handshake.
// Left operations are done as a right shift on bit-reversed data. The operand is
// reversed before stage 0 and reversed back on the way into the last stage.
module pipelined_barrel_shifter #(
  parameter int unsigned WIDTH = 8,
  localparam int unsigned SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         op,
  input  logic               direction,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [WIDTH-1:0]   din,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   dout
);

  localparam int unsigned LAST = SHAMT_W - 1;

  // Per-stage registers. rem_q holds the shift-amount bits that later stages still need;
  // bit 0 of rem_q[k] is the enable for stage k+1.
  logic [WIDTH-1:0]   data_q  [SHAMT_W];
  logic               valid_q [SHAMT_W];
  logic [1:0]         op_q    [SHAMT_W];
  logic               dir_q   [SHAMT_W];
  logic               sign_q  [SHAMT_W];
  logic [SHAMT_W-1:0] rem_q   [SHAMT_W];

  logic [WIDTH-1:0]   data_nxt  [SHAMT_W];
  logic               valid_nxt [SHAMT_W];
  logic [1:0]         op_nxt    [SHAMT_W];
  logic               dir_nxt   [SHAMT_W];
  logic               sign_nxt  [SHAMT_W];
  logic [SHAMT_W-1:0] rem_nxt   [SHAMT_W];

  logic [WIDTH-1:0]   x0;
  logic [SHAMT_W-1:0] rem_cur;
  logic               advance;

  function automatic logic [WIDTH-1:0] bit_rev(input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] r;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      r[i] = x[WIDTH-1-i];
    end
    return r;
  endfunction

  // One stage: optional right shift by 2^k. Rotate wraps modulo WIDTH. Arithmetic right
  // shifts fill with the sign bit; everything else fills with 0. The last stage also undoes
  // the left-operation reversal.
  function automatic logic [WIDTH-1:0] stage_shift(
    input logic [WIDTH-1:0] x,
    input logic [1:0]       o,
    input logic             dir,
    input logic             sign,
    input logic             en,
    input int unsigned      k
  );
    logic [WIDTH-1:0] r;
    int unsigned amt;
    int unsigned src;
    amt = 32'd1 << k;
    r = x;
    if (en) begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        src = i + amt;
        if (src < WIDTH || o[1]) begin
          r[i] = x[SHAMT_W'(src)];
        end else begin
          r[i] = (o == 2'b01 && !dir) ? sign : 1'b0;
        end
      end
    end
    if (k == LAST && dir) begin
      r = bit_rev(r);
    end
    return r;
  endfunction

  // The whole pipe moves as one; a stalled output freezes every stage, bubbles included.
  always_comb begin
    advance   = !valid_q[LAST] || out_ready;
    in_ready  = advance;
    out_valid = valid_q[LAST];
    dout      = data_q[LAST];
  end

  // Next value of every stage register: stage 0 takes the inputs, stage k takes stage k-1.
  always_comb begin
    for (int unsigned k = 0; k < SHAMT_W; k++) begin
      data_nxt[k]  = '0;
      valid_nxt[k] = 1'b0;
      op_nxt[k]    = '0;
      dir_nxt[k]   = 1'b0;
      sign_nxt[k]  = 1'b0;
      rem_nxt[k]   = '0;
    end
    rem_cur = '0;

    x0           = direction ? bit_rev(din) : din;
    data_nxt[0]  = stage_shift(x0, op, direction, din[WIDTH-1], shamt[0], 0);
    valid_nxt[0] = in_valid;
    op_nxt[0]    = op;
    dir_nxt[0]   = direction;
    sign_nxt[0]  = din[WIDTH-1];
    rem_nxt[0]   = shamt >> 1;

    for (int unsigned k = 1; k < SHAMT_W; k++) begin
      rem_cur      = rem_q[k-1];
      data_nxt[k]  = stage_shift(data_q[k-1], op_q[k-1], dir_q[k-1], sign_q[k-1], rem_cur[0], k);
      valid_nxt[k] = valid_q[k-1];
      op_nxt[k]    = op_q[k-1];
      dir_nxt[k]   = dir_q[k-1];
      sign_nxt[k]  = sign_q[k-1];
      rem_nxt[k]   = rem_cur >> 1;
    end
  end

  // Stage registers: clear on reset, load when the pipe advances, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < SHAMT_W; k++) begin
        data_q[k]  <= '0;
        valid_q[k] <= 1'b0;
        op_q[k]    <= '0;
        dir_q[k]   <= 1'b0;
        sign_q[k]  <= 1'b0;
        rem_q[k]   <= '0;
      end
    end else if (advance) begin
      for (int unsigned k = 0; k < SHAMT_W; k++) begin
        data_q[k]  <= data_nxt[k];
        valid_q[k] <= valid_nxt[k];
        op_q[k]    <= op_nxt[k];
        dir_q[k]   <= dir_nxt[k];
        sign_q[k]  <= sign_nxt[k];
        rem_q[k]   <= rem_nxt[k];
      end
    end
  end

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Self-checking bench for pipelined_barrel_shifter (WIDTH=8, latency 3).
module tb_pipelined_barrel_shifter;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   op;
  logic         direction;
  logic [2:0]   shamt;
  logic [W-1:0] din;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] dout;

  int checks   = 0;
  int failures = 0;

  pipelined_barrel_shifter #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .direction (direction),
    .shamt     (shamt),
    .din       (din),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout      (dout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] op;
    logic       dir;
    logic [2:0] sh;
    logic [7:0] din;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model built from the plain operator definitions of shift and rotate.
  function automatic logic [7:0] ref_shift(input logic [1:0] o, input logic d,
                                           input logic [2:0] s, input logic [7:0] x);
    logic [7:0] r;
    int unsigned n;
    n = s;
    case (o)
      2'b00:   r = d ? (x << n) : (x >> n);
      2'b01:   r = d ? (x << n) : 8'($signed(x) >>> n);
      default: r = d ? ((x << n) | (x >> (8 - n))) : ((x >> n) | (x << (8 - n)));
    endcase
    return r;
  endfunction

  // Scoreboard: expected results are queued in acceptance order and compared in delivery order.
  logic [7:0] exp_q[$];
  logic [7:0] sb_exp;
  bit sb_en    = 1'b0;
  bit last_acc = 1'b0;
  int accepted  = 0;
  int delivered = 0;

  always @(negedge clk) begin
    if (sb_en) begin
      last_acc = in_valid && in_ready;
      if (last_acc) begin
        exp_q.push_back(ref_shift(op, direction, shamt, din));
        accepted++;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("rand_extra_result", 32'(dout), 32'hFFFF_FFFF);
        end else begin
          sb_exp = exp_q.pop_front();
          check("rand_dout", 32'(dout), 32'(sb_exp));
        end
        delivered++;
      end
    end
  end

  task automatic run_one(input vec_t v);
    int lat;
    op        = v.op;
    direction = v.dir;
    shamt     = v.sh;
    din       = v.din;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    check("vec_latency", 32'(lat), 32'd3);
    check("vec_dout", 32'(dout), 32'(v.exp));
    step();
  endtask

  initial begin
    logic [7:0] exp4 [4];
    int  sent;
    int  got;
    int  cyc;
    bit  stalled;
    bit  xi;
    bit  xo;

    vecs.push_back('{2'b00, 1'b0, 3'd3, 8'hB6, 8'h16});
    vecs.push_back('{2'b01, 1'b0, 3'd3, 8'hB6, 8'hF6});
    vecs.push_back('{2'b01, 1'b1, 3'd1, 8'h81, 8'h02});
    vecs.push_back('{2'b10, 1'b1, 3'd3, 8'hB6, 8'hB5});
    vecs.push_back('{2'b11, 1'b0, 3'd1, 8'h01, 8'h80});
    vecs.push_back('{2'b00, 1'b1, 3'd0, 8'hA5, 8'hA5});
    vecs.push_back('{2'b01, 1'b0, 3'd0, 8'h5A, 8'h5A});
    vecs.push_back('{2'b10, 1'b1, 3'd0, 8'hC3, 8'hC3});
    vecs.push_back('{2'b11, 1'b0, 3'd0, 8'h3C, 8'h3C});
    vecs.push_back('{2'b00, 1'b1, 3'd7, 8'hFF, 8'h80});
    vecs.push_back('{2'b01, 1'b0, 3'd7, 8'h80, 8'hFF});
    vecs.push_back('{2'b01, 1'b0, 3'd4, 8'h70, 8'h07});
    vecs.push_back('{2'b10, 1'b0, 3'd7, 8'hB6, 8'h6D});
    vecs.push_back('{2'b00, 1'b0, 3'd7, 8'hFF, 8'h01});

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    op        = 2'b00;
    direction = 1'b0;
    shamt     = 3'd0;
    din       = 8'h00;
    step();
    step();
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_dout", 32'(dout), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;
    step();

    // Directed vectors: one operation at a time, latency and result.
    foreach (vecs[i]) run_one(vecs[i]);

    // Back-to-back inputs with backpressure after the first result.
    exp4[0] = 8'h02;
    exp4[1] = 8'h04;
    exp4[2] = 8'h06;
    exp4[3] = 8'h08;
    sent = 0;
    got = 0;
    stalled = 1'b0;
    op = 2'b00;
    direction = 1'b1;
    shamt = 3'd1;
    din = 8'h01;
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 60 && got < 4; c++) begin
      if (out_valid && !stalled) begin
        out_ready = 1'b0;
        #1;
        check("bp_in_ready_falls", 32'(in_ready), 32'd0);
        for (int h = 0; h < 3; h++) begin
          step();
          check("bp_hold_valid", 32'(out_valid), 32'd1);
          check("bp_hold_dout", 32'(dout), 32'h02);
          check("bp_in_ready_low", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        stalled = 1'b1;
      end
      @(negedge clk);
      xi = in_valid && in_ready;
      xo = out_valid && out_ready;
      if (xo) begin
        check("bp_order", 32'(dout), 32'(exp4[got]));
        got++;
      end
      step();
      if (xi) begin
        sent++;
        if (sent == 4) in_valid = 1'b0;
        else din = 8'(sent + 1);
      end
    end
    check("bp_delivered", 32'(got), 32'd4);
    check("bp_sent", 32'(sent), 32'd4);
    repeat (5) step();
    check("bp_no_extra", 32'(out_valid), 32'd0);

    // Reset with three operations in flight.
    out_ready = 1'b0;
    op = 2'b10;
    direction = 1'b0;
    shamt = 3'd1;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      din = 8'($urandom);
      step();
    end
    in_valid = 1'b0;
    check("pre_rst_out_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    step();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_dout", 32'(dout), 32'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      check("rst_no_stale", 32'(out_valid), 32'd0);
    end

    // Random operations with random backpressure against the reference model.
    in_valid = 1'b0;
    sb_en = 1'b1;
    cyc = 0;
    while (delivered < 10000 && cyc < 80000) begin
      step();
      cyc++;
      if (!in_valid || last_acc) begin
        if (accepted < 10000 && $urandom_range(3) != 0) begin
          op        = 2'($urandom_range(3));
          direction = 1'($urandom_range(1));
          shamt     = 3'($urandom_range(7));
          din       = 8'($urandom);
          in_valid  = 1'b1;
        end else begin
          in_valid = 1'b0;
        end
      end
      out_ready = ($urandom_range(3) != 0);
    end
    sb_en = 1'b0;
    check("rand_accepted", 32'(accepted), 32'd10000);
    check("rand_delivered", 32'(delivered), 32'd10000);
    check("rand_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
